// File: rtl/spi_slave_trx_fifo_if.sv
// spi_slave_trx_fifo_if: TX push / RX pop handshake bundle and FIFO levels.
// master drives pushes and pops, slave is the transceiver.
interface spi_slave_trx_fifo_if #(
  parameter int CHAR_NBITS = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [CHAR_NBITS-1:0] S_TX_DATA;
  logic                  S_TX_VALID;
  logic                  S_TX_READY;
  logic [CHAR_NBITS-1:0] S_RX_DATA;
  logic                  S_RX_VALID;
  logic                  S_RX_READY;
  logic [LW-1:0]         S_TX_LEVEL;
  logic [LW-1:0]         S_RX_LEVEL;

  modport master (
    output S_TX_DATA, S_TX_VALID, S_RX_READY,
    input  S_TX_READY, S_RX_DATA, S_RX_VALID,
    input  S_TX_LEVEL, S_RX_LEVEL
  );

  modport slave (
    input  S_TX_DATA, S_TX_VALID, S_RX_READY,
    output S_TX_READY, S_RX_DATA, S_RX_VALID,
    output S_TX_LEVEL, S_RX_LEVEL
  );
endinterface

// File: rtl/spi_slave_trx_fifo.sv
// spi_slave_trx_fifo: oversampling SPI slave with TX/RX character FIFOs.
// Define SPI_SLV_PARTIAL_CHAR_EN to push partial characters on CS release.
module spi_slave_trx_fifo #(
  parameter int                    CHAR_NBITS = 32,
  parameter int                    LEN_W      = 5,
  parameter int                    FIFO_DEPTH = 8,
  parameter logic [CHAR_NBITS-1:0] IDLE_CHAR  = '1
) (
  input  logic               S_SYSCLK,
  input  logic               S_RESETN,
  input  logic               S_ENABLE,
  input  logic               S_CPOL,
  input  logic               S_CPHA,
  input  logic               S_REV,
  input  logic [LEN_W-1:0]   S_CHAR_LEN,
  spi_slave_trx_fifo_if.slave bus,
  output logic               S_CHAR_DONE,
  output logic               S_RX_OVF,
  output logic               S_TX_UNF,
  input  logic               S_CLR_ERR,
  input  logic               S_SPI_CS,
  input  logic               S_SPI_SCK,
  input  logic               S_SPI_MOSI,
  output logic               S_SPI_MISO,
  output logic               S_SPI_MISO_OE
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = LEN_W + 1;

  typedef logic [CHAR_NBITS-1:0] char_t;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t           state;
  logic [2:0]       cs_q;
  logic [2:0]       sck_q;
  logic [1:0]       mosi_q;
  logic             cpol_q;
  logic             cpha_q;
  logic             rev_q;
  logic [LEN_W-1:0] len_q;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    len_p1;
  char_t            tx_sr;
  char_t            rx_sr;
  char_t            rx_ins;
  char_t            tx_shl;
  char_t            tx_next;
  logic             fresh;

  char_t            tx_mem [FIFO_DEPTH];
  char_t            rx_mem [FIFO_DEPTH];
  logic [PW-1:0]    tx_wp, tx_rp;
  logic [PW-1:0]    rx_wp, rx_rp;
  logic             tx_full, tx_empty;
  logic             rx_full, rx_empty;
  logic             tx_push, tx_pop;
  logic             rx_push, rx_pop;

  logic cs_fall, cs_rise;
  logic lead, trail;
  logic sample_e, shift_e;
  logic word_done, part_done;
  logic load_go, reload, take;
  logic ovf_set, unf_set;

  function automatic logic head(input char_t w, input logic r,
                                input logic [LEN_W-1:0] l);
    return r ? w[l] : w[0];
  endfunction

  // [0],[1] synchronise, [2] holds the previous synced level
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      cs_q   <= 3'b111;
      sck_q  <= '0;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[1:0], S_SPI_CS};
      sck_q  <= {sck_q[1:0], S_SPI_SCK};
      mosi_q <= {mosi_q[0], S_SPI_MOSI};
    end
  end

  assign cs_fall  = !cs_q[1] && cs_q[2];
  assign cs_rise  = cs_q[1] && !cs_q[2];
  assign lead     = (sck_q[1] != cpol_q) && (sck_q[2] == cpol_q);
  assign trail    = (sck_q[1] == cpol_q) && (sck_q[2] != cpol_q);
  assign sample_e = cpha_q ? trail : lead;
  assign shift_e  = cpha_q ? lead : trail;

  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                    (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                    (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

  assign bus.S_TX_READY = !tx_full;
  assign bus.S_RX_VALID = !rx_empty;
  assign bus.S_RX_DATA  = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];
  assign bus.S_TX_LEVEL = tx_wp - tx_rp;
  assign bus.S_RX_LEVEL = rx_wp - rx_rp;

  assign len_p1    = {1'b0, len_q} + CW'(1);
  assign word_done = S_ENABLE && (state == SHIFT) && (cnt == len_p1);

`ifdef SPI_SLV_PARTIAL_CHAR_EN
  assign part_done = S_ENABLE && (state == SHIFT) && cs_rise &&
                     (cnt != '0) && (cnt != len_p1);
`else
  assign part_done = 1'b0;
`endif

  assign load_go = S_ENABLE && (state == LOAD) && !cs_rise;
  assign reload  = word_done && !cs_rise;
  assign take    = load_go || reload;
  assign tx_next = tx_empty ? IDLE_CHAR : tx_mem[tx_rp[AW-1:0]];
  assign unf_set = take && tx_empty;

  assign tx_push = S_ENABLE && bus.S_TX_VALID && !tx_full;
  assign tx_pop  = take && !tx_empty;
  assign rx_pop  = S_ENABLE && bus.S_RX_READY && !rx_empty;
  // a same-cycle pop frees the slot the push needs
  assign rx_push = (word_done || part_done) && (!rx_full || rx_pop);
  assign ovf_set = (word_done || part_done) && rx_full && !rx_pop;

  always_comb begin
    rx_ins = rx_sr;
    if (rev_q) rx_ins = {rx_sr[CHAR_NBITS-2:0], mosi_q[1]};
    else       rx_ins[cnt[LEN_W-1:0]] = mosi_q[1];
  end

  assign tx_shl = rev_q ? (tx_sr << 1) : (tx_sr >> 1);

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else if (!S_ENABLE) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
    end
  end

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      tx_mem <= '{default: '0};
      rx_mem <= '{default: '0};
    end else begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.S_TX_DATA;
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sr;
    end
  end

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      S_RX_OVF <= 1'b0;
      S_TX_UNF <= 1'b0;
    end else begin
      S_RX_OVF <= ovf_set || (S_RX_OVF && !S_CLR_ERR);
      S_TX_UNF <= unf_set || (S_TX_UNF && !S_CLR_ERR);
    end
  end

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      state         <= IDLE;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      rev_q         <= 1'b0;
      len_q         <= '0;
      cnt           <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      fresh         <= 1'b0;
      S_SPI_MISO    <= 1'b0;
      S_SPI_MISO_OE <= 1'b0;
      S_CHAR_DONE   <= 1'b0;
    end else begin
      S_CHAR_DONE <= word_done || part_done;
      if (!S_ENABLE || (state != IDLE && cs_rise)) begin
        state         <= IDLE;
        cnt           <= '0;
        fresh         <= 1'b0;
        S_SPI_MISO    <= 1'b0;
        S_SPI_MISO_OE <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cpol_q        <= S_CPOL;
            cpha_q        <= S_CPHA;
            rev_q         <= S_REV;
            len_q         <= S_CHAR_LEN;
            S_SPI_MISO_OE <= 1'b0;
            if (cs_fall) state <= LOAD;
          end
          LOAD: begin
            tx_sr         <= tx_next;
            rx_sr         <= '0;
            cnt           <= '0;
            fresh         <= cpha_q;
            S_SPI_MISO    <= head(tx_next, rev_q, len_q);
            S_SPI_MISO_OE <= 1'b1;
            state         <= SHIFT;
          end
          SHIFT: begin
            // fresh: next shift edge presents bit 0 of a new char
            if (word_done) begin
              tx_sr <= tx_next;
              rx_sr <= '0;
              cnt   <= '0;
              fresh <= 1'b1;
            end else begin
              if (sample_e) begin
                rx_sr <= rx_ins;
                cnt   <= cnt + CW'(1);
              end
              if (shift_e) begin
                if (fresh) begin
                  fresh      <= 1'b0;
                  S_SPI_MISO <= head(tx_sr, rev_q, len_q);
                end else begin
                  tx_sr      <= tx_shl;
                  S_SPI_MISO <= head(tx_shl, rev_q, len_q);
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
